md_unit: RTL and testbench

Parametrised multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core. It sits beside the ALU in the EX stage and executes mult/multu/div/divu/madd/maddu/msub/msubu over a configurable number of cycles, plus single-cycle mthi/mtlo. It exposes `busy` so the hazard unit can stall any following MD instruction or mfhi/mflo until results are architecturally visible.

---
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO for the MIPS EX stage.
// Results are computed at issue into a holding register and released after a fixed latency.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   hold;

  op_e                  opc;
  logic [2*WIDTH-1:0]   ext_a_s, ext_b_s, ext_a_u, ext_b_u;
  logic [2*WIDTH-1:0]   prod_s, prod_u, acc, res;
  logic [WIDTH-1:0]     q_s, r_s, q_u, r_u, most_neg;
  logic                 is_mul, is_div, sovf;

  assign opc     = op_e'(op);
  assign ext_a_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
  assign ext_b_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign ext_a_u = {{WIDTH{1'b0}}, src_a};
  assign ext_b_u = {{WIDTH{1'b0}}, src_b};
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_s  = ext_a_s * ext_b_s;
  assign prod_u  = ext_a_u * ext_b_u;
  assign acc     = {hi, lo};

  assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  assign sovf     = (src_a == most_neg) && (src_b == '1);
  assign q_s      = $signed(src_a) / $signed(src_b);
  assign r_s      = $signed(src_a) % $signed(src_b);
  assign q_u      = src_a / src_b;
  assign r_u      = src_a % src_b;

  always_comb begin
    res    = '0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (opc)
      OP_MULT:  begin is_mul = 1'b1; res = prod_s;       end
      OP_MULTU: begin is_mul = 1'b1; res = prod_u;       end
      OP_MADD:  begin is_mul = 1'b1; res = acc + prod_s; end
      OP_MADDU: begin is_mul = 1'b1; res = acc + prod_u; end
      OP_MSUB:  begin is_mul = 1'b1; res = acc - prod_s; end
      OP_MSUBU: begin is_mul = 1'b1; res = acc - prod_u; end
      OP_DIV: begin
        is_div = 1'b1;
        if (src_b == '0)  res = {src_a, {WIDTH{1'b1}}};
        else if (sovf)    res = {{WIDTH{1'b0}}, most_neg};
        else              res = {r_s, q_s};
      end
      OP_DIVU: begin
        is_div = 1'b1;
        if (src_b == '0)  res = {src_a, {WIDTH{1'b1}}};
        else              res = {r_u, q_u};
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              hold  <= res;
              cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end else if (opc == OP_MTHI) begin
              hi <= src_a;
            end else if (opc == OP_MTLO) begin
              lo <= src_a;
            end
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            {hi, lo} <= hold;
            cnt      <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed issues checked by literals and by an arithmetic
// model compared against the outputs on every cycle.
module tb_md_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining latency plus pending result, arithmetic on 64-bit values.
  int          rem = 0;
  logic [31:0] mhi = '0, mlo = '0, phi = '0, plo = '0;
  bit          mdone = 1'b0;

  function automatic logic [63:0] md_result(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (o)
      4'd1:  return sp;
      4'd2:  return up;
      4'd7:  return cur + sp;
      4'd8:  return cur + up;
      4'd9:  return cur - sp;
      4'd10: return cur - up;
      4'd3: begin
        if (sb == 0) return {a, 32'hFFFF_FFFF};
        if (sa == 32'sh8000_0000 && sb == -1) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      rem = 0; mhi = '0; mlo = '0; mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mhi = phi; mlo = plo; mdone = 1'b1;
        end
      end else if (start) begin
        if (op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10}) begin
          {phi, plo} = md_result(op, src_a, src_b, {mhi, mlo});
          rem = NM;
        end else if (op inside {4'd3, 4'd4}) begin
          {phi, plo} = md_result(op, src_a, src_b, {mhi, mlo});
          rem = ND;
        end else if (op == 4'd5) mhi = src_a;
        else if (op == 4'd6) mlo = src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 64'(busy), 64'(rem > 0));
      chk("model_done", 64'(done), 64'(mdone));
      chk("model_hi", 64'(hi), 64'(mhi));
      chk("model_lo", 64'(lo), 64'(mlo));
    end
  end

  // Drive an issue now (at a falling edge) and hold it for one cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = '0; src_a = '0; src_b = '0;
  endtask

  task automatic wait_done(output int nbusy);
    int n;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    nbusy = n;
  endtask

  task automatic run_md(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_done(n);
    chk({name, "_busycycles"}, 64'(n), 64'(lat));
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int n, dcount;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    run_md("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("mult_done_single", 64'(done), 64'd0);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, NM, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", 4'd4, 32'd7, 32'd2, ND, 32'd1, 32'd3);
    run_md("div_zero", 4'd3, 32'd5, 32'd0, ND, 32'd5, 32'hFFFF_FFFF);
    run_md("divu_zero", 4'd4, 32'h8000_0001, 32'd0, ND, 32'h8000_0001, 32'hFFFF_FFFF);
    run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000);

    issue(4'd5, 32'h1234_5678, 32'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    issue(4'd6, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    run_md("madd", 4'd7, 32'd2, 32'd3, NM, 32'h1234_5678, 32'h9ABC_DEF6);
    run_md("msubu", 4'd10, 32'd1, 32'h9ABC_DEF7, NM, 32'h1234_5677, 32'hFFFF_FFFF);
    run_md("madd_chain", 4'd7, 32'd1, 32'd1, NM, 32'h1234_5678, 32'h0000_0000);
    run_md("maddu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'h1234_5676, 32'h0000_0001);
    run_md("msub", 4'd9, 32'hFFFF_FFFF, 32'd1, NM, 32'h1234_5676, 32'h0000_0002);

    issue(4'd12, 32'hDEAD_BEEF, 32'd3);
    chk("badop_busy", 64'(busy), 64'd0);
    chk("badop_hilo", {hi, lo}, 64'h1234_5676_0000_0002);

    issue(4'd3, 32'd100, 32'd7);
    issue(4'd1, 32'd3, 32'd3);
    wait_done(n);
    chk("ignored_busycycles", 64'(n), 64'(ND - 1));
    chk("ignored_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("ignored_no_second_op", 64'(dcount), 64'd0);

    issue(4'd3, 32'd50, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
